// File: rtl/keypad_pkg.sv
// Shared types for the keypad event queue.
// Key code constants and debounce FSM states.
package keypad_pkg;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with count/full/empty.
// A push while full is accepted only if a pop frees a slot that cycle.
module sync_fifo #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign dropped = push && !do_push;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/keypad_event_queue.sv
// Keypad scanner front end: synchronise, debounce, queue key-down events.
// One event per debounced press; CPU drains codes from a FWFT FIFO.
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 200000,
  parameter  int DEPTH           = 8,
  localparam int CW              = $clog2(DEPTH) + 1,
  localparam int DW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_press,
  input  logic [CODE_W-1:0] raw_code,
  input  logic              rd_en,
  output logic [CODE_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              key_held,
  output logic [CODE_W-1:0] held_code
);

  localparam logic [DW-1:0] DONE     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DCNT_MAX = {DW{1'b1}};

  logic              press_s1_q, press_s2_q;
  logic [CODE_W-1:0] code_s1_q, code_s2_q;

  deb_state_e        state_q, state_d;
  logic [DW-1:0]     dcnt_q, dcnt_d, dcnt_inc;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] held_code_q, held_code_d;
  logic              key_held_q, key_held_d;
  logic              push_q, push_d;
  logic              overflow_q, overflow_d;
  logic              fifo_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_s1_q <= 1'b0;
      press_s2_q <= 1'b0;
      code_s1_q  <= '0;
      code_s2_q  <= '0;
    end else begin
      press_s1_q <= raw_press;
      press_s2_q <= press_s1_q;
      code_s1_q  <= raw_code;
      code_s2_q  <= code_s1_q;
    end
  end

  // Saturate so a stalled state can never wrap into a false match.
  assign dcnt_inc = (dcnt_q == DCNT_MAX) ? dcnt_q : dcnt_q + DW'(1);

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    cand_d      = cand_q;
    held_code_d = held_code_q;
    key_held_d  = key_held_q;
    push_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_s2_q) begin
          cand_d  = code_s2_q;
          dcnt_d  = DW'(1);
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!press_s2_q) begin
          state_d = IDLE;
        end else if (code_s2_q != cand_q) begin
          cand_d = code_s2_q;
          dcnt_d = DW'(1);
        end else if (dcnt_q == DONE) begin
          push_d      = 1'b1;
          held_code_d = cand_q;
          key_held_d  = 1'b1;
          state_d     = HELD;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end
      HELD: begin
        if (!press_s2_q) begin
          dcnt_d  = DW'(1);
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (press_s2_q) begin
          state_d = HELD;
        end else if (dcnt_q == DONE) begin
          key_held_d = 1'b0;
          state_d    = IDLE;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      cand_q      <= '0;
      held_code_q <= '0;
      key_held_q  <= 1'b0;
      push_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      cand_q      <= cand_d;
      held_code_q <= held_code_d;
      key_held_q  <= key_held_d;
      push_q      <= push_d;
    end
  end

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_q),
    .wdata   (held_code_q),
    .pop     (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .dropped (fifo_drop)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign key_held  = key_held_q;
  assign held_code = held_code_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Scoreboard bench for keypad_event_queue.
// Reference: stable-run-length debounce rule plus a queue-based FIFO.
module tb_keypad_event_queue;

  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw_press = 1'b0;
  logic [3:0] raw_code = '0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [3:0] rd_data;
  logic       empty, full, overflow, key_held;
  logic [2:0] count;
  logic [3:0] held_code;

  int checks = 0;
  int errors = 0;

  keypad_event_queue #(
    .DEBOUNCE_CYCLES (D),
    .DEPTH           (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_press (raw_press),
    .raw_code  (raw_code),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .key_held  (key_held),
    .held_code (held_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0d expected %0d",
                 name, $time, act, exp);
    end
  endtask

  // Reference model state
  logic [3:0] mq[$];
  logic [3:0] exp_q[$];
  int         run = 0;
  int         zrun = 0;
  logic       held = 1'b0;
  logic [3:0] cand = '0;
  logic [3:0] hcode = '0;
  logic       ev_pend = 1'b0;
  logic [3:0] ev_code = '0;
  logic       ovf = 1'b0;
  logic       d1p = 1'b0, d2p = 1'b0;
  logic [3:0] d1c = '0, d2c = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        exp_q.delete();
        run = 0; zrun = 0; held = 1'b0;
        cand = '0; hcode = '0; ev_pend = 1'b0; ev_code = '0;
        ovf = 1'b0;
        d1p = 1'b0; d2p = 1'b0; d1c = '0; d2c = '0;
      end else begin
        bit drop;
        bit fire;
        if (rd_en && mq.size() > 0) void'(mq.pop_front());
        drop = 0;
        if (ev_pend) begin
          if (mq.size() < DEPTH) begin
            mq.push_back(ev_code);
            exp_q.push_back(ev_code);
          end else begin
            drop = 1;
          end
        end
        if (drop) ovf = 1'b1;
        else if (clr_ovf) ovf = 1'b0;
        // A press counts once its code has been seen D cycles in a row;
        // a release once the press has been absent D cycles in a row.
        fire = 0;
        if (!held) begin
          if (!d2p) run = 0;
          else if (run == 0 || d2c != cand) begin
            cand = d2c;
            run = 1;
          end else run++;
          if (run == D) begin
            fire = 1; held = 1'b1; hcode = cand; run = 0; zrun = 0;
          end
        end else begin
          if (d2p) zrun = 0;
          else zrun++;
          if (zrun == D) begin
            held = 1'b0; zrun = 0;
          end
        end
        ev_pend = fire;
        ev_code = cand;
        d2p = d1p; d2c = d1c;
        d1p = raw_press; d1c = raw_code;
      end
    end
  end

  // Monitor: status outputs after each edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("count", int'(count), mq.size());
      chk("empty", int'(empty), int'(mq.size() == 0));
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("overflow", int'(overflow), int'(ovf));
      chk("key_held", int'(key_held), int'(held));
      chk("held_code", int'(held_code), int'(hcode));
      chk("rd_data_head", int'(rd_data),
          mq.size() > 0 ? int'(mq[0]) : 0);
    end
  end

  // Monitor: popped data against scoreboard queue
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rd_en && !empty) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          chk("pop_data", int'(rd_data), int'(e));
        end
      end
    end
  end

  task automatic tick(input logic p, input logic [3:0] c,
                      input logic rd, input logic clr);
    raw_press = p;
    raw_code  = c;
    rd_en     = rd;
    clr_ovf   = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic press_rel(input logic [3:0] c, input int on, input int off);
    for (int i = 0; i < on; i++) tick(1'b1, c, 1'b0, 1'b0);
    for (int i = 0; i < off; i++) tick(1'b0, c, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] codes [5];
    bit seen;
    codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
    @(posedge clk); #2;
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(1'b0, 4'd0, 1'b0, 1'b0);

    // Clean press
    press_rel(4'd5, 20, 20);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b0);

    // Press bounce then code 7
    tick(1'b1, 4'd7, 1'b0, 1'b0);
    tick(1'b0, 4'd7, 1'b0, 1'b0);
    tick(1'b1, 4'd7, 1'b0, 1'b0);
    tick(1'b0, 4'd7, 1'b0, 1'b0);
    press_rel(4'd7, 20, 20);
    tick(1'b0, 4'd0, 1'b1, 1'b0);

    // Code glitch during debounce
    press_rel(4'd3, 2, 0);
    press_rel(4'd9, 20, 20);
    tick(1'b0, 4'd0, 1'b1, 1'b0);

    // Release bounce
    press_rel(4'd2, 20, 2);
    press_rel(4'd2, 2, 20);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b0);

    // Overflow: five events into four slots
    foreach (codes[i]) press_rel(codes[i], 12, 12);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 4'd0, 1'b1, 1'b0);
      tick(1'b0, 4'd0, 1'b0, 1'b0);
    end
    tick(1'b0, 4'd0, 1'b0, 1'b1);
    tick(1'b0, 4'd0, 1'b0, 1'b0);

    // Full queue: push coincides with pop
    press_rel(4'hA, 12, 12);
    press_rel(4'hB, 12, 12);
    press_rel(4'hC, 12, 12);
    press_rel(4'hD, 12, 12);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1'b1, 4'hE, 1'b0, 1'b0);
      if (ev_pend) seen = 1;
    end
    chk("push_pop_event_seen", int'(seen), 1);
    tick(1'b1, 4'hE, 1'b1, 1'b0);
    press_rel(4'hE, 4, 20);

    // Reset during debounce with key still down
    press_rel(4'h8, 4, 0);
    rst = 1'b1;
    tick(1'b1, 4'h8, 1'b0, 1'b0);
    tick(1'b1, 4'h8, 1'b0, 1'b0);
    rst = 1'b0;
    press_rel(4'h8, 20, 20);
    for (int i = 0; i < 2; i++) tick(1'b0, 4'd0, 1'b1, 1'b0);

    // Randomized presses, bounces, reads and overflow clears
    for (int n = 0; n < 150; n++) begin
      logic [3:0] c;
      int on, off;
      c   = 4'($urandom_range(0, 15));
      on  = $urandom_range(1, 12);
      off = $urandom_range(1, 12);
      for (int i = 0; i < on; i++) begin
        logic [3:0] cc;
        cc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : c;
        tick(($urandom_range(0, 7) != 0), cc,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
      end
      for (int i = 0; i < off; i++)
        tick(($urandom_range(0, 7) == 0), c,
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    // Drain
    for (int i = 0; i < 20; i++) tick(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      if (mq.size() == 0) break;
      tick(1'b0, 4'd0, 1'b1, 1'b0);
    end
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    chk("drained_scoreboard", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
